// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for a shared tri-state datapath. Grants one owner at a time, enforces
// a per-ownership cycle limit, and inserts one dead cycle between owners for bus turnaround.
module bus_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rel,
  input  logic            err_clr,
  output logic [NREQ-1:0] grant,
  output logic [OW-1:0]   owner,
  output logic            busy,
  output logic            timeout_err,
  output logic [OW-1:0]   err_id
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [OW-1:0]   err_id_q, err_id_d;

  logic [OW-1:0] win;
  logic          found;
  int            idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  logic          own_rel, own_req, cnt_hit;
  logic [OW-1:0] ptr_next;

  always_comb begin
    own_rel  = rel[owner_q];
    own_req  = req[owner_q];
    cnt_hit  = (cnt_q == CW'(TIMEOUT));
    ptr_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_clr ? 1'b0 : err_q;
    err_id_d = err_id_q;
    unique case (state_q)
      StIdle, StTurn: begin
        grant_d = '0;
        if (found) begin
          state_d      = StGrant;
          grant_d[win] = 1'b1;
          owner_d      = win;
          cnt_d        = CW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (own_rel || !own_req || cnt_hit) begin
          state_d = StTurn;
          grant_d = '0;
          ptr_d   = ptr_next;
          // A revocation by timeout overrides a simultaneous clear.
          if (!own_rel && own_req) begin
            err_d    = 1'b1;
            err_id_d = owner_q;
          end
        end else if (!cnt_hit) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NREQ=4, TIMEOUT=8): vector table, directed corner
// sequences and a randomized run against an ownership-level reference model.
module tb_bus_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic       err_clr = 1'b0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_id;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .err_clr    (err_clr),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_id     (err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; rel = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive inputs away from the edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic c);
    @(negedge clk);
    req = r; rel = l; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, whether we are in the dead cycle, and how long held.
  bit m_has_owner, m_gap, m_err;
  int m_owner, m_ptr, m_held, m_eid;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_has_owner = 0; m_gap = 0; m_err = 0;
    m_owner = 0; m_ptr = 0; m_held = 0; m_eid = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic c);
    int w;
    if (c) m_err = 0;
    if (m_has_owner) begin
      if (l[m_owner] || !r[m_owner] || m_held == TO) begin
        if (!l[m_owner] && r[m_owner]) begin
          m_err = 1;
          m_eid = m_owner;
        end
        m_has_owner = 0;
        m_gap = 1;
        m_ptr = (m_owner + 1) % NREQ;
      end else begin
        m_held++;
      end
    end else begin
      m_gap = 0;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_has_owner = 1;
        m_owner = w;
        m_held = 1;
      end
    end
  endtask

  initial begin
    logic [3:0] r, l;
    logic       c;
    logic [3:0] exp_g;

    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b1};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    tbl[8]  = '{4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b1};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    tbl[11] = '{4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b1};
    tbl[12] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};

    // Reset state and single-requester latency.
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(timeout_err), 32'h0);
    check("rst_err_id", 32'(err_id), 32'h0);
    step(4'b0100, 4'b0000, 1'b0);
    check("lat_grant", 32'(grant), 32'h4);
    check("lat_owner", 32'(owner), 32'h2);
    check("lat_busy", 32'(busy), 32'h1);
    step(4'b0000, 4'b0000, 1'b0);
    check("drop_turn_grant", 32'(grant), 32'h0);
    check("drop_turn_busy", 32'(busy), 32'h1);
    step(4'b0000, 4'b0000, 1'b0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_owner_hold", 32'(owner), 32'h2);

    // Round-robin rotation with release on each owner's second cycle.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].req, tbl[i].rel, 1'b0);
      check($sformatf("rr_grant[%0d]", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("rr_owner[%0d]", i), 32'(owner), 32'(tbl[i].owner));
      check($sformatf("rr_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
    end

    // Non-owner release is ignored; dropping req ends ownership.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0);
    check("nr_grant0", 32'(grant), 32'h2);
    step(4'b0010, 4'b0100, 1'b0);
    check("nr_grant1", 32'(grant), 32'h2);
    step(4'b0000, 4'b0100, 1'b0);
    check("nr_turn_grant", 32'(grant), 32'h0);
    check("nr_turn_busy", 32'(busy), 32'h1);
    step(4'b0000, 4'b0000, 1'b0);
    check("nr_idle_busy", 32'(busy), 32'h0);

    // Timeout revokes after exactly TO cycles, same requester regains alone.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      step(4'b0001, 4'b0000, 1'b0);
      check($sformatf("to_grant[%0d]", i), 32'(grant), 32'h1);
      check($sformatf("to_err[%0d]", i), 32'(timeout_err), 32'h0);
    end
    step(4'b0001, 4'b0000, 1'b0);
    check("to_turn_grant", 32'(grant), 32'h0);
    check("to_err_set", 32'(timeout_err), 32'h1);
    check("to_err_id", 32'(err_id), 32'h0);
    step(4'b0001, 4'b0000, 1'b0);
    check("to_regrant", 32'(grant), 32'h1);
    step(4'b0001, 4'b0000, 1'b1);
    check("to_err_clr", 32'(timeout_err), 32'h0);

    // Clear coinciding with a new timeout on owner 3: timeout wins.
    do_reset();
    for (int i = 0; i < TO; i++) step(4'b1000, 4'b0000, 1'b0);
    check("tc_grant", 32'(grant), 32'h8);
    step(4'b1000, 4'b0000, 1'b1);
    check("tc_err", 32'(timeout_err), 32'h1);
    check("tc_err_id", 32'(err_id), 32'h3);
    check("tc_grant_off", 32'(grant), 32'h0);

    // Asynchronous reset mid-grant, then arbitration restarts from pointer 0.
    do_reset();
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b1010, 4'b0010, 1'b0);
    step(4'b1010, 4'b0000, 1'b0);
    check("ar_pre_grant", 32'(grant), 32'h8);
    @(negedge clk);
    #2;
    rst = 1'b0; req = '0; rel = '0;
    #1;
    check("ar_grant_async", 32'(grant), 32'h0);
    check("ar_busy_async", 32'(busy), 32'h0);
    check("ar_owner_async", 32'(owner), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(4'b1010, 4'b0000, 1'b0);
    check("ar_post_grant", 32'(grant), 32'h2);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    r = 4'(($urandom));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) r = 4'($urandom);
      l = 4'($urandom & $urandom & $urandom);
      c = ($urandom_range(0, 15) == 0);
      step(r, l, c);
      model_step(r, l, c);
      exp_g = m_has_owner ? 4'(1 << m_owner) : 4'b0000;
      check("rnd_grant", 32'(grant), 32'(exp_g));
      check("rnd_busy", 32'(busy), 32'(m_has_owner || m_gap));
      check("rnd_owner", 32'(owner), 32'(m_owner));
      check("rnd_err", 32'(timeout_err), 32'(m_err));
      check("rnd_err_id", 32'(err_id), 32'(m_eid));
      check("rnd_onehot", 32'($onehot0(grant)), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
